// File: rtl/osd_spi_master.sv
// -----------------------------------------------------------------------------
// osd_spi_master
//
// SPI initiator (mode 0, MSB first) for the OSD command channel. Sends
// enable/disable command frames and line-write frames whose payload bytes are
// fetched from a synchronous-read line RAM one byte ahead of the shifter.
//
// Optional feature macro: OSD_SPI_BURST_EN
//   defined   : adds cmd_len[11:0], the payload byte count for op2
//               (0 -> 1 byte, values above 2048 clamp to 2048)
//   undefined : op2 always sends 256 payload bytes
//
// Parameters
//   CLK_DIV   SCK half-period in clk_sys cycles (2..255)
//   SS_GAP    min clk_sys cycles SPI_SS3 stays high between frames (>=1)
//
// Ports
//   clk_sys    in   system clock
//   reset_n    in   asynchronous active-low reset
//   cmd_valid  in   command request
//   cmd_ready  out  high only while idle; accept on cmd_valid & cmd_ready
//   cmd_op     in   0=disable, 1=enable, 2=write line, 3=reserved (no-op)
//   cmd_line   in   start line for a write
//   cmd_len    in   payload byte count (OSD_SPI_BURST_EN only)
//   rd_en      out  one-cycle payload read strobe
//   rd_addr    out  payload byte address {line,byte}
//   rd_data    in   payload byte, valid one cycle after rd_en
//   busy       out  frame in progress, inter-frame gap included
//   done       out  one-cycle pulse when frame and gap are complete
//   SPI_SCK    out  serial clock, idle low
//   SPI_SS3    out  OSD chip select, active low
//   SPI_DI     out  serial data, MSB first
// -----------------------------------------------------------------------------
module osd_spi_master #(
  parameter int CLK_DIV = 2,
  parameter int SS_GAP  = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_line,
`ifdef OSD_SPI_BURST_EN
  input  logic [11:0] cmd_len,
`endif
  output logic        rd_en,
  output logic [10:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic        done,
  output logic        SPI_SCK,
  output logic        SPI_SS3,
  output logic        SPI_DI
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_TAIL,
    S_GAP
  } state_t;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_M1 = 16'(SS_GAP - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [11:0] r_nload;   // payload bytes already moved into the shifter
  logic [11:0] r_total;   // payload bytes in this frame (0 for op0/op1)
  logic [7:0]  r_sh;
  logic [7:0]  r_hold;
  logic        r_cap;
  logic        r_rd_en;
  logic [10:0] r_rd_addr;
  logic        r_busy;
  logic        r_done;
  logic        r_ready;
  logic        r_sck;
  logic        r_ss;
  logic        r_di;

  logic [7:0]  w_cmd_byte;
  logic [11:0] w_total;
  logic        w_tick;
  logic        w_last;

  always_comb begin
    w_cmd_byte = 8'h40;
    case (cmd_op)
      2'd1:    w_cmd_byte = 8'h41;
      2'd2:    w_cmd_byte = {5'b00100, cmd_line};
      default: w_cmd_byte = 8'h40;
    endcase
  end

  always_comb begin
    w_total = 12'd0;
    if (cmd_op == 2'd2) begin
`ifdef OSD_SPI_BURST_EN
      if (cmd_len == 12'd0)
        w_total = 12'd1;
      else if (cmd_len > 12'd2048)
        w_total = 12'd2048;
      else
        w_total = cmd_len;
`else
      w_total = 12'd256;
`endif
    end
  end

  assign w_tick = (r_cnt == DIV_M1);
  // The byte being shifted is the last one once every payload byte is loaded.
  assign w_last = (r_nload == r_total);

  // Holding register: the RAM answers one cycle after rd_en, so r_cap marks
  // the cycle in which rd_data carries the prefetched byte.
  always_ff @(posedge clk_sys) begin
    if (r_cap)
      r_hold <= rd_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_nload   <= '0;
      r_total   <= '0;
      r_sh      <= '0;
      r_cap     <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
      r_sck     <= 1'b0;
      r_ss      <= 1'b1;
      r_di      <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      r_cap   <= r_rd_en;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_ready) begin
            if (cmd_op == 2'd3) begin
              r_done <= 1'b1;
            end else begin
              // Entering LOAD: select the slave and present the command MSB.
              r_state <= S_LOAD;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              r_ss    <= 1'b0;
              r_di    <= w_cmd_byte[7];
              r_sh    <= w_cmd_byte;
              r_total <= w_total;
              r_nload <= '0;
              r_bit   <= '0;
              r_cnt   <= '0;
              if (cmd_op == 2'd2) begin
                r_rd_en   <= 1'b1;
                r_rd_addr <= {cmd_line, 8'h00};
              end
            end
          end
        end
        S_LOAD: begin
          if (w_tick) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_SHIFT: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (!r_sck) begin
              r_sck <= 1'b1;
            end else begin
              r_sck <= 1'b0;
              r_bit <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                if (w_last) begin
                  r_state <= S_TAIL;
                end else begin
                  // Byte boundary: next byte follows with no idle SCK period.
                  r_sh    <= r_hold;
                  r_di    <= r_hold[7];
                  r_nload <= r_nload + 12'd1;
                  if (r_nload + 12'd1 != r_total) begin
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= r_rd_addr + 11'd1;
                  end
                end
              end else begin
                r_sh <= {r_sh[6:0], 1'b0};
                r_di <= r_sh[6];
              end
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_TAIL: begin
          if (w_tick) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
            r_ss    <= 1'b1;
            r_di    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_M1) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign SPI_SCK   = r_sck;
  assign SPI_SS3   = r_ss;
  assign SPI_DI    = r_di;

endmodule
